// File: rtl/simd_v2_if.sv
// Host bus for simd_v2: chip select, strobes, write data, and registered read/status back.
interface simd_v2_if #(
  parameter int unsigned BW = 8
);
  logic          cs;
  logic          wr;
  logic          rd;
  logic          ad;
  logic          exec;
  logic [BW-1:0] din;
  logic [BW-1:0] dout;
  logic          busy;
  logic          done;

  modport master (output cs, wr, rd, ad, exec, din, input dout, busy, done);
  modport slave  (input cs, wr, rd, ad, exec, din, output dout, busy, done);
endinterface

// File: rtl/simd_v2.sv
// Register-mapped SIMD engine: one lane per cycle of add/sub/mul/MAC into a result buffer.
// Define SIMD_V2_SAT_EN for saturating arithmetic; otherwise results wrap modulo 2^BW.
module simd_v2 #(
  parameter int unsigned LANES = 32,
  parameter int unsigned BW    = 8
) (
  input  logic     clk,
  input  logic     rst,
  simd_v2_if.slave bus
);
  localparam int unsigned AW        = $clog2(2*LANES+2);
  localparam int unsigned LW        = $clog2(LANES);
  localparam int unsigned MODE_ADDR = 2*LANES;
  localparam int unsigned STAT_ADDR = 2*LANES+1;

  typedef enum logic [0:0] {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] lane_q, lane_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          start_c;

  logic [AW-1:0] addr_q;
  logic [BW-1:0] a_q [LANES];
  logic [BW-1:0] b_q [LANES];
  logic [BW-1:0] r_q [LANES];
  logic [1:0]    mode_q;
  logic [LW-1:0] rptr_q;
  logic [BW-1:0] dout_q;
  logic          done_sticky_q;

  logic          addr_wr_c, data_wr_c, rd_data_c, rd_stat_c;
  logic          is_a_c, is_b_c, is_mode_c, is_stat_c, blocked_c;
  logic [AW-1:0] addr_inc_c;
  logic [LW-1:0] a_idx_c, b_idx_c, rptr_inc_c;
  logic [BW-1:0] a_l, b_l, r_l, lane_res_c;

  // Bus decode; operand/mode writes stall the address while lanes are computing
  always_comb begin
    addr_wr_c  = bus.cs & bus.wr & bus.ad;
    data_wr_c  = bus.cs & bus.wr & ~bus.ad;
    is_a_c     = addr_q < AW'(LANES);
    is_b_c     = (addr_q >= AW'(LANES)) && (addr_q < AW'(MODE_ADDR));
    is_mode_c  = addr_q == AW'(MODE_ADDR);
    is_stat_c  = addr_q == AW'(STAT_ADDR);
    blocked_c  = busy_q & (is_a_c | is_b_c | is_mode_c);
    rd_data_c  = bus.cs & bus.rd & ~busy_q & (addr_q < AW'(STAT_ADDR));
    rd_stat_c  = bus.cs & bus.rd & ~busy_q & is_stat_c;
    addr_inc_c = is_stat_c ? '0 : addr_q + AW'(1);
    a_idx_c    = LW'(addr_q);
    b_idx_c    = LW'(addr_q - AW'(LANES));
    rptr_inc_c = (rptr_q == LW'(LANES-1)) ? '0 : rptr_q + LW'(1);
  end

  assign a_l = a_q[lane_q];
  assign b_l = b_q[lane_q];
  assign r_l = r_q[lane_q];

`ifdef SIMD_V2_SAT_EN
  logic [BW:0]     sum_c, diff_c;
  logic [2*BW-1:0] prod_c;
  logic [2*BW:0]   mac_c;

  // Full-width intermediates so overflow/borrow can be detected and clamped
  always_comb begin
    sum_c  = {1'b0, a_l} + {1'b0, b_l};
    diff_c = {1'b0, a_l} - {1'b0, b_l};
    prod_c = (2*BW)'(a_l) * (2*BW)'(b_l);
    mac_c  = (2*BW+1)'(r_l) + (2*BW+1)'(prod_c);
    case (mode_q)
      2'd0:    lane_res_c = sum_c[BW] ? '1 : sum_c[BW-1:0];
      2'd1:    lane_res_c = diff_c[BW] ? '0 : diff_c[BW-1:0];
      2'd2:    lane_res_c = (|prod_c[2*BW-1:BW]) ? '1 : prod_c[BW-1:0];
      default: lane_res_c = (|mac_c[2*BW:BW]) ? '1 : mac_c[BW-1:0];
    endcase
  end
`else
  always_comb begin
    case (mode_q)
      2'd0:    lane_res_c = a_l + b_l;
      2'd1:    lane_res_c = a_l - b_l;
      2'd2:    lane_res_c = a_l * b_l;
      default: lane_res_c = r_l + a_l * b_l;
    endcase
  end
`endif

  // Lane sequencer: exec starts a pass, done follows the last lane
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    start_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cs && bus.exec) begin
          state_d = RUN;
          lane_d  = '0;
          busy_d  = 1'b1;
          start_c = 1'b1;
        end
      end
      RUN: begin
        if (lane_q == LW'(LANES-1)) begin
          state_d = IDLE;
          lane_d  = '0;
          done_d  = 1'b1;
        end else begin
          lane_d  = lane_q + LW'(1);
          busy_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lane_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q        <= '0;
      mode_q        <= '0;
      rptr_q        <= '0;
      dout_q        <= '0;
      done_sticky_q <= 1'b0;
      for (int unsigned i = 0; i < LANES; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
        r_q[i] <= '0;
      end
    end else begin
      if (addr_wr_c) begin
        addr_q <= bus.din[AW-1:0];
      end else if (data_wr_c && !blocked_c) begin
        if (is_a_c)         a_q[a_idx_c] <= bus.din;
        else if (is_b_c)    b_q[b_idx_c] <= bus.din;
        else if (is_mode_c) mode_q       <= bus.din[1:0];
        addr_q <= addr_inc_c;
      end

      if (state_q == RUN) r_q[lane_q] <= lane_res_c;

      if (rd_data_c) dout_q <= r_q[rptr_q];
      else if (rd_stat_c) dout_q <= {busy_q, done_sticky_q, (BW-2)'(0)};

      if (start_c)        rptr_q <= '0;
      else if (rd_data_c) rptr_q <= rptr_inc_c;

      if (done_d)         done_sticky_q <= 1'b1;
      else if (rd_stat_c) done_sticky_q <= 1'b0;
    end
  end

  assign bus.dout = dout_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_simd_v2.sv
// Directed bench for simd_v2 at LANES=4, BW=8; expectations follow SIMD_V2_SAT_EN when defined.
module tb_simd_v2;
  localparam int unsigned LANES = 4;
  localparam int unsigned BW    = 8;

`ifdef SIMD_V2_SAT_EN
  localparam logic [7:0] E_SUB0 = 8'h00;
  localparam logic [7:0] E_SUB1 = 8'h00;
  localparam logic [7:0] E_MAC1 = 8'hFF;
  localparam logic [7:0] E_MAC2 = 8'hFF;
  localparam logic [7:0] E_ADD  = 8'hFF;
`else
  localparam logic [7:0] E_SUB0 = 8'hFC;
  localparam logic [7:0] E_SUB1 = 8'hEE;
  localparam logic [7:0] E_MAC1 = 8'h00;
  localparam logic [7:0] E_MAC2 = 8'h00;
  localparam logic [7:0] E_ADD  = 8'd44;
`endif

  logic clk = 1'b0;
  logic rst;
  int   total  = 0;
  int   passed = 0;
  int   bc, dc;

  always #5 clk = ~clk;

  simd_v2_if #(.BW(BW)) bus ();

  simd_v2 #(.LANES(LANES), .BW(BW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle();
    bus.cs = 1'b0; bus.wr = 1'b0; bus.rd = 1'b0; bus.ad = 1'b0; bus.exec = 1'b0; bus.din = '0;
  endtask

  task automatic strobe(input logic w, input logic r, input logic a, input logic e, input logic [7:0] d);
    bus.cs = 1'b1; bus.wr = w; bus.rd = r; bus.ad = a; bus.exec = e; bus.din = d;
    @(negedge clk);
    idle();
  endtask

  task automatic set_addr(input logic [7:0] a); strobe(1'b1, 1'b0, 1'b1, 1'b0, a);    endtask
  task automatic wdata(input logic [7:0] d);    strobe(1'b1, 1'b0, 1'b0, 1'b0, d);    endtask
  task automatic exec_go();                     strobe(1'b0, 1'b0, 1'b0, 1'b1, 8'h0); endtask

  task automatic rd_chk(input logic [7:0] exp, input string tag);
    strobe(1'b0, 1'b1, 1'b0, 1'b0, 8'h0);
    chk(32'(bus.dout), 32'(exp), tag);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (bus.done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(32'(bus.done), 32'd1, tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.cs = 1'b1; bus.wr = 1'b1; bus.ad = 1'b1; bus.rd = 1'b1; bus.exec = 1'b1; bus.din = 8'h05;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle();
  endtask

  task automatic count_window(input int cycles);
    bc = 0;
    dc = 0;
    for (int i = 0; i < cycles; i++) begin
      if (bus.busy === 1'b1) bc++;
      if (bus.done === 1'b1) dc++;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0] sums [5];
    sums[0] = 8'd11; sums[1] = 8'd22; sums[2] = 8'd33; sums[3] = 8'd44; sums[4] = 8'd11;
    rst = 1'b1;
    idle();
    @(negedge clk);

    // Reset with every strobe asserted
    do_reset();
    chk(32'(bus.dout), 32'h0, "reset_dout");
    chk(32'(bus.busy), 32'h0, "reset_busy");
    chk(32'(bus.done), 32'h0, "reset_done");

    // Four-lane add, busy/done timing, status sticky, read-pointer wrap
    set_addr(8'd0);
    wdata(8'd1);  wdata(8'd2);  wdata(8'd3);  wdata(8'd4);
    wdata(8'd10); wdata(8'd20); wdata(8'd30); wdata(8'd40);
    wdata(8'd0);
    exec_go();
    count_window(8);
    chk(32'(bc), 32'd4, "add_busy_cycles");
    chk(32'(dc), 32'd1, "add_done_pulses");
    rd_chk(8'h40, "status_after_done");
    rd_chk(8'h00, "status_cleared");
    set_addr(8'd0);
    for (int i = 0; i < 5; i++) rd_chk(sums[i], $sformatf("add_lane%0d", i));

    // Subtract underflow in lanes 0 and 1
    set_addr(8'd0); wdata(8'd5);
    set_addr(8'd4); wdata(8'd9);
    set_addr(8'd8); wdata(8'd1);
    exec_go();
    wait_done("sub_done");
    set_addr(8'd0);
    rd_chk(E_SUB0, "sub_lane0");
    rd_chk(E_SUB1, "sub_lane1");

    // MAC twice with 16*16; status write discarded and address wraps to A0
    do_reset();
    set_addr(8'd8);
    wdata(8'd3);
    wdata(8'hAA);
    for (int i = 0; i < 8; i++) wdata(8'd16);
    exec_go();
    wait_done("mac1_done");
    set_addr(8'd0);
    rd_chk(E_MAC1, "mac1_lane0");
    exec_go();
    wait_done("mac2_done");
    set_addr(8'd0);
    for (int i = 0; i < 4; i++) rd_chk(E_MAC2, $sformatf("mac2_lane%0d", i));

    // Add overflow and an in-range multiply
    set_addr(8'd0); wdata(8'd200);
    set_addr(8'd4); wdata(8'd100);
    set_addr(8'd8); wdata(8'd0);
    exec_go();
    wait_done("addov_done");
    set_addr(8'd0);
    rd_chk(E_ADD, "add_overflow");
    set_addr(8'd0); wdata(8'd3);
    set_addr(8'd4); wdata(8'd7);
    set_addr(8'd8); wdata(8'd2);
    exec_go();
    wait_done("mul_done");
    set_addr(8'd0);
    rd_chk(8'd21, "mul_lane0");

    // Writes, reads and exec while busy
    do_reset();
    set_addr(8'd0);
    for (int i = 0; i < 8; i++) wdata(8'd1);
    wdata(8'd0);
    exec_go();
    chk(32'(bus.busy), 32'd1, "busy_after_exec");
    strobe(1'b0, 1'b1, 1'b0, 1'b0, 8'h0);
    chk(32'(bus.dout), 32'h0, "rd_busy_hold");
    set_addr(8'd0);
    wdata(8'h55);
    exec_go();
    count_window(6);
    chk(32'(dc), 32'd1, "busy_single_done");
    chk(32'(bc), 32'd0, "exec_not_queued");
    wdata(8'd7);
    exec_go();
    wait_done("busy_rerun_done");
    set_addr(8'd0);
    rd_chk(8'd8, "addr_held_lane0");
    rd_chk(8'd2, "operand_held_lane1");

    // Reset during lane 2 of a pass
    exec_go();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk(32'(bus.busy), 32'h0, "abort_busy");
    chk(32'(bus.done), 32'h0, "abort_done");
    chk(32'(bus.dout), 32'h0, "abort_dout");
    count_window(6);
    chk(32'(dc), 32'd0, "abort_no_done");
    set_addr(8'd9);
    rd_chk(8'h00, "abort_status");
    set_addr(8'd0);
    for (int i = 0; i < 4; i++) rd_chk(8'h00, $sformatf("abort_r%0d", i));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/simd_v2.md
SIMD_V2 -- requirements
Module: simd_v2

Interface
REQ-001 The module SHALL have parameter LANES, default 32, giving the number of SIMD lanes (>=2).
REQ-002 The module SHALL have parameter BW, default 8, giving the lane width and the bus width in bits.
REQ-003 The module SHALL have localparam AW = $clog2(2*LANES+2), giving the address register width.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The module SHALL have port cs, input, 1 bit: chip select; when low, wr/rd/exec are ignored.
REQ-007 The module SHALL have port wr, input, 1 bit: write strobe; each sampled-high cycle is one write.
REQ-008 The module SHALL have port rd, input, 1 bit: read strobe; each sampled-high cycle is one read.
REQ-009 The module SHALL have port ad, input, 1 bit: 1 = the write targets the address register, 0 = the write targets data.
REQ-010 The module SHALL have port exec, input, 1 bit: start-execution strobe.
REQ-011 The module SHALL have port din, input, BW bits: write data.
REQ-012 The module SHALL have port dout, output, BW bits: registered read data.
REQ-013 The module SHALL have port busy, output, 1 bit: high while lanes are being computed.
REQ-014 The module SHALL have port done, output, 1 bit: one-cycle pulse when a computation completes.

Function
REQ-015 The address map SHALL be: 0..LANES-1 = operand A; LANES..2*LANES-1 = operand B; 2*LANES = mode; 2*LANES+1 = status (read-only).
REQ-016 cs&wr&ad SHALL load addr <= din[AW-1:0].
REQ-017 cs&wr&!ad SHALL write din to the addressed register, then increment addr, wrapping 2*LANES+1 -> 0.
REQ-018 Data writes to a status address or an out-of-range address SHALL be discarded, and addr SHALL still increment.
REQ-019 Data writes to operands or mode while busy=1 SHALL be discarded, and addr SHALL NOT increment.
REQ-020 Mode[1:0] SHALL select the lane operation: 0 = A+B, 1 = A-B, 2 = low BW bits of A*B, 3 = MAC, i.e. R[i] <= R[i] + A[i]*B[i] (low BW bits).
REQ-021 The FSM SHALL have states IDLE and RUN; cs&exec in IDLE SHALL enter RUN with lane counter 0 and rptr 0.
REQ-022 In RUN, one lane per cycle SHALL be computed into result buffer R[lane].
REQ-023 After lane LANES-1 the FSM SHALL return to IDLE, with done high for exactly the following cycle.
REQ-024 busy SHALL be high for exactly LANES cycles per execution.
REQ-025 exec while in RUN SHALL be ignored; it SHALL NOT be queued.
REQ-026 cs&rd&!busy with addr<2*LANES+1 SHALL load dout <= R[rptr] next cycle, then rptr++, wrapping LANES-1 -> 0.
REQ-027 cs&rd&!busy with addr==2*LANES+1 SHALL load dout <= {busy, done_sticky, 0...}, clearing done_sticky; rptr SHALL be unchanged.
REQ-028 rd while busy SHALL be ignored; dout SHALL hold.
REQ-029 wr and rd asserted in the same cycle SHALL both take effect independently.
REQ-030 done_sticky SHALL be set by done and cleared by a status read; on the same cycle, set SHALL win.
REQ-031 All arithmetic SHALL be unsigned at BW bits.

Reset
REQ-032 rst SHALL clear addr, A, B, mode, R, rptr, lane counter, dout, done_sticky, busy and done to 0 and force IDLE.
REQ-033 rst asserted in RUN SHALL abort the operation, with no done pulse.
REQ-034 rst SHALL take precedence over every simultaneous strobe.

Configuration
REQ-035 With SIMD_V2_SAT_EN defined, add, MAC and mul SHALL clamp to 2^BW-1 and sub SHALL clamp to 0.
REQ-036 Without SIMD_V2_SAT_EN, all operations SHALL wrap modulo 2^BW.

Verification (LANES=4, BW=8)
REQ-037 Write addr 0, data 1,2,3,4,10,20,30,40, mode 0, exec, then 4 reads -> dout 11,22,33,44, with busy high 4 cycles and done pulse once.
REQ-038 Mode 1, A=5, B=9 in lane 0 -> R[0]=0xFC without SIMD_V2_SAT_EN, and 0x00 with it.
REQ-039 Mode 3, A=B=16 all lanes, exec twice -> R=0x00 wrapped (256+256) without SIMD_V2_SAT_EN, and 0xFF with it.
REQ-040 Operand write and second exec while busy -> operands unchanged, addr unchanged, single done pulse.
REQ-041 rst at lane 2 of RUN -> busy=0 next cycle, no done, R all 0, dout 0.
REQ-042 Status read after done -> dout[7:6]=01, and an immediate second status read -> 00.
